trv_bus_responder: RTL and testbench
====================================

// Module: trv_bus_responder
// PURPOSE
//  Data-side bus responder for the TRV32I core: answers bus_read_en / bus_write_en
//  requests from the core with word-wide data memory plus one tohost MMIO register.
//  Sits between the core's data bus port and the testbench; tohost replaces ad-hoc
//  end-of-test detection. Programmable wait states exercise core stall handling.
// PARAMETERS
//  B_WIDTH      32       data bus width (bits); byte lanes = B_WIDTH/8
//  ADDR_WIDTH   12       byte-address width decoded; memory depth = 2**(ADDR_WIDTH-2) words
//  WAIT_CYCLES  1        extra cycles between request accept and bus_ready (0..15)
//  TOHOST_ADDR  'hFFC    byte address of tohost register (word aligned, above memory is not required)
// PORTS
//  clk             in   1              system clock, all logic on rising edge
//  rst             in   1              synchronous reset, active-high
//  bus_addr        in   ADDR_WIDTH     byte address; bits [1:0] ignored (word aligned)
//  bus_read_en     in   1              read request
//  bus_write_en    in   1              write request
//  bus_byte_en     in   B_WIDTH/8      write lane enables (ignored on read)
//  bus_write_data  in   B_WIDTH        write data
//  bus_read_data   out  B_WIDTH        read data, valid only while bus_ready=1
//  bus_ready       out  1              one-cycle completion pulse
//  bus_err         out  1              one-cycle error pulse, coincident with bus_ready
//  tohost_valid    out  1              sticky: tohost has been written
//  tohost_data     out  B_WIDTH        last value written to tohost
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state->IDLE, counter=0, bus_read_data=0, bus_ready=0,
//    bus_err=0, tohost_valid=0, tohost_data=0. Memory array NOT cleared.
//  - FSM states: IDLE, WAIT, RESP.
//    IDLE: if read_en|write_en -> latch addr/data/byte_en/kind, counter=WAIT_CYCLES;
//          go WAIT if WAIT_CYCLES>0 else RESP.
//    WAIT: counter decrements each cycle; at counter==1 -> RESP.
//    RESP: bus_ready=1 for exactly this cycle; perform write / drive read data; -> IDLE.
//  - Latency: request seen in cycle N -> bus_ready in cycle N+1+WAIT_CYCLES.
//  - Request is latched at accept; requester may change inputs afterwards. Requests
//    arriving while not IDLE are ignored (core must hold until ready, then re-issue).
//  - Back-to-back: request present in the RESP cycle is not accepted; accepted next IDLE cycle.
//  - Read: bus_read_data = mem[addr[ADDR_WIDTH-1:2]]; zero whenever bus_ready=0.
//  - Write: only lanes with byte_en[i]=1 update; byte_en=0 completes normally, no change.
//  - tohost: write to TOHOST_ADDR updates tohost_data (full word, byte_en ignored), sets
//    tohost_valid; memory not written. Read of TOHOST_ADDR returns tohost_data.
//  - Error: read_en & write_en both 1 at accept -> no memory/tohost effect, read data 0,
//    bus_err=1 with bus_ready. Latched kind is ERR; still takes full latency.
//  - Reset mid-transaction: transaction dropped, no bus_ready, pending write not performed.
//  - WAIT_CYCLES>15 is a parameter error (elaboration assertion).
// STRUCTURE
//  - trv_bus_pkg: typedef enum logic [1:0] {IDLE, WAIT, RESP} bus_state_t;
//    typedef enum {REQ_RD, REQ_WR, REQ_ERR} bus_req_t; shared between responder,
//    future instruction-side responder and bench monitors.
//  - Sub-module trv_sram_word: word array, synchronous byte-lane write, combinational
//    read; instantiated once. FSM, counter, tohost and muxing stay in top.
// TESTING
//  1 WAIT_CYCLES=1: write 0xDEADBEEF @0x010, byte_en=4'hF, then read @0x010 -> ready 2 cycles
//    after each request, read data 0xDEADBEEF, bus_err=0.
//  2 Byte lanes: word @0x020=0x11223344, write 0xAABBCCDD byte_en=4'b0101 -> read 0x11BB33DD.
//  3 WAIT_CYCLES=0 and 3: read latency exactly 1 and 4 cycles; bus_read_data 0 outside ready.
//  4 read_en=write_en=1 @0x030 (holding 0x5) -> bus_ready&bus_err pulse, mem @0x030 still 0x5.
//  5 write 0x00000001 @TOHOST_ADDR -> tohost_valid=1, tohost_data=1; bench ends test;
//    read @TOHOST_ADDR returns 1.
//  6 Start write 0xCAFEF00D @0x040 with WAIT_CYCLES=3, assert rst in WAIT -> no bus_ready,
//    later read @0x040 returns prior content; outputs at reset values.

Source files
------------

// File: rtl/trv_bus_pkg.sv
// trv_bus_pkg: types shared by the data-side responder, a future
// instruction-side responder and bench monitors.
//   bus_state_t : responder FSM state (IDLE, WAIT, RESP)
//   bus_req_t   : kind of request latched at accept (read, write, error)
package trv_bus_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} bus_state_t;

   typedef enum {REQ_RD, REQ_WR, REQ_ERR} bus_req_t;

   // Largest wait-state count the 4-bit counter can hold.
   localparam int unsigned MAX_WAIT_CYCLES = 15;

endpackage

// File: rtl/trv_bus_responder_if.sv
// trv_bus_responder_if: core data bus plus tohost MMIO view.
//   master : drives bus_addr, bus_read_en, bus_write_en, bus_byte_en,
//            bus_write_data; observes the responses.
//   slave  : drives bus_read_data, bus_ready, bus_err, tohost_valid,
//            tohost_data and the debug state.
// Handshake: a request (bus_read_en or bus_write_en high) is taken on a
// rising edge only while the responder is IDLE; requests in any other
// state are ignored and the master must re-issue. Completion is the
// one-cycle bus_ready pulse; bus_read_data and bus_err are meaningful
// only in that cycle, and bus_read_data is zero in every other cycle.
interface trv_bus_responder_if import trv_bus_pkg::*; #(
   parameter int B_WIDTH    = 32,
   parameter int ADDR_WIDTH = 12
);
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic                  bus_read_en;
   logic                  bus_write_en;
   logic [B_WIDTH/8-1:0]  bus_byte_en;
   logic [B_WIDTH-1:0]    bus_write_data;
   logic [B_WIDTH-1:0]    bus_read_data;
   logic                  bus_ready;
   logic                  bus_err;
   logic                  tohost_valid;
   logic [B_WIDTH-1:0]    tohost_data;
   bus_state_t            state;

   modport master (
      output bus_addr, bus_read_en, bus_write_en, bus_byte_en, bus_write_data,
      input  bus_read_data, bus_ready, bus_err, tohost_valid, tohost_data, state
   );

   modport slave (
      input  bus_addr, bus_read_en, bus_write_en, bus_byte_en, bus_write_data,
      output bus_read_data, bus_ready, bus_err, tohost_valid, tohost_data, state
   );
endinterface

// File: rtl/trv_sram_word.sv
// trv_sram_word: word-wide memory, synchronous byte-lane write,
// combinational read. Contents are not reset.
//   clk   : write clock
//   we    : write strobe
//   be    : per-byte lane enables for the write
//   addr  : word index (shared by read and write)
//   wdata : write data
//   rdata : combinational read of mem[addr]
module trv_sram_word #(
   parameter int DW = 32,
   parameter int AW = 10
) (
   input  logic            clk,
   input  logic            we,
   input  logic [DW/8-1:0] be,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   wdata,
   output logic [DW-1:0]   rdata
);
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      for (int i = 0; i < DW/8; i++) begin
         if (we && be[i]) begin
            mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   assign rdata = mem[addr];
endmodule

// File: rtl/trv_bus_responder.sv
// trv_bus_responder: data-side bus responder for the TRV32I core.
// Word memory plus a tohost MMIO register, with WAIT_CYCLES programmable
// wait states between request accept and the bus_ready pulse.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of trv_bus_responder_if (request in, response out,
//         tohost_valid/tohost_data, debug state)
module trv_bus_responder import trv_bus_pkg::*; #(
   parameter int                    B_WIDTH     = 32,
   parameter int                    ADDR_WIDTH  = 12,
   parameter int unsigned           WAIT_CYCLES = 1,
   parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 'hFFC
) (
   input logic                clk,
   input logic                rst,
   trv_bus_responder_if.slave bus
);
   localparam int LANES = B_WIDTH / 8;
   localparam int WA    = ADDR_WIDTH - 2;

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_WAIT = WAIT;
   localparam logic [1:0] S_RESP = RESP;

   localparam logic [3:0]    WAIT_LD   = WAIT_CYCLES[3:0];
   localparam logic [WA-1:0] TOHOST_WI = TOHOST_ADDR[ADDR_WIDTH-1:2];

   if (WAIT_CYCLES > MAX_WAIT_CYCLES) begin : g_bad_wait_cycles
      $error("trv_bus_responder: WAIT_CYCLES must be 0..15");
   end

   logic [1:0]         state;
   logic [3:0]         cnt;
   logic [WA-1:0]      lat_widx;
   logic [B_WIDTH-1:0] lat_wdata;
   logic [LANES-1:0]   lat_be;
   bus_req_t           lat_kind;
   logic               lat_tohost;
   logic               tohost_valid_q;
   logic [B_WIDTH-1:0] tohost_data_q;

   logic               req;
   logic               resp;
   logic               mem_we;
   logic [B_WIDTH-1:0] mem_rdata;
   logic [B_WIDTH-1:0] rd_word;
   logic               addr_lsb_unused;

   assign req  = bus.bus_read_en | bus.bus_write_en;
   assign resp = (state == S_RESP);

   // Word aligned bus: the byte offset carries no information.
   assign addr_lsb_unused = ^bus.bus_addr[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         cnt            <= '0;
         lat_widx       <= '0;
         lat_wdata      <= '0;
         lat_be         <= '0;
         lat_kind       <= REQ_RD;
         lat_tohost     <= 1'b0;
         tohost_valid_q <= 1'b0;
         tohost_data_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  lat_widx   <= bus.bus_addr[ADDR_WIDTH-1:2];
                  lat_wdata  <= bus.bus_write_data;
                  lat_be     <= bus.bus_byte_en;
                  lat_tohost <= (bus.bus_addr[ADDR_WIDTH-1:2] == TOHOST_WI);
                  if (bus.bus_read_en && bus.bus_write_en) lat_kind <= REQ_ERR;
                  else if (bus.bus_read_en)                lat_kind <= REQ_RD;
                  else                                     lat_kind <= REQ_WR;
                  cnt   <= WAIT_LD;
                  state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               // Counter is loaded with WAIT_CYCLES, so leaving at 1 gives
               // exactly WAIT_CYCLES cycles in this state.
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= S_RESP;
            end
            S_RESP: begin
               state <= S_IDLE;
               if (lat_kind == REQ_WR && lat_tohost) begin
                  tohost_valid_q <= 1'b1;
                  tohost_data_q  <= lat_wdata;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Reset on the RESP edge drops the write along with the transaction.
   assign mem_we = resp && (lat_kind == REQ_WR) && !lat_tohost && !rst;

   trv_sram_word #(
      .DW (B_WIDTH),
      .AW (WA)
   ) u_sram (
      .clk   (clk),
      .we    (mem_we),
      .be    (lat_be),
      .addr  (lat_widx),
      .wdata (lat_wdata),
      .rdata (mem_rdata)
   );

   assign rd_word = lat_tohost ? tohost_data_q : mem_rdata;

   assign bus.bus_ready     = resp;
   assign bus.bus_err       = resp && (lat_kind == REQ_ERR);
   assign bus.bus_read_data = (resp && lat_kind == REQ_RD) ? rd_word : '0;
   assign bus.tohost_valid  = tohost_valid_q;
   assign bus.tohost_data   = tohost_data_q;
   assign bus.state         = bus_state_t'(state);
endmodule

// File: tb/tb_trv_bus_responder.sv
// Bench for trv_bus_responder: three instances (WAIT_CYCLES 0, 1, 3) share
// one request stream gated by a per-instance mask; a per-instance word
// array and tohost model predict every response.
module tb_trv_bus_responder;
   import trv_bus_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] addr;
   logic        rd;
   logic        wr;
   logic [3:0]  be;
   logic [31:0] wd;
   logic [2:0]  mask;

   always #5 clk = ~clk;

   trv_bus_responder_if #(.B_WIDTH(32), .ADDR_WIDTH(12)) b0 ();
   trv_bus_responder_if #(.B_WIDTH(32), .ADDR_WIDTH(12)) b1 ();
   trv_bus_responder_if #(.B_WIDTH(32), .ADDR_WIDTH(12)) b3 ();

   assign b0.bus_addr = addr;  assign b0.bus_read_en = rd & mask[0];  assign b0.bus_write_en = wr & mask[0];
   assign b0.bus_byte_en = be; assign b0.bus_write_data = wd;
   assign b1.bus_addr = addr;  assign b1.bus_read_en = rd & mask[1];  assign b1.bus_write_en = wr & mask[1];
   assign b1.bus_byte_en = be; assign b1.bus_write_data = wd;
   assign b3.bus_addr = addr;  assign b3.bus_read_en = rd & mask[2];  assign b3.bus_write_en = wr & mask[2];
   assign b3.bus_byte_en = be; assign b3.bus_write_data = wd;

   trv_bus_responder #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   trv_bus_responder #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
   trv_bus_responder #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

   logic [31:0] rdat [3];
   logic        rdy  [3];
   logic        err  [3];
   logic        tv   [3];
   logic [31:0] td   [3];
   bus_state_t  st   [3];

   assign rdat[0] = b0.bus_read_data; assign rdy[0] = b0.bus_ready; assign err[0] = b0.bus_err;
   assign rdat[1] = b1.bus_read_data; assign rdy[1] = b1.bus_ready; assign err[1] = b1.bus_err;
   assign rdat[2] = b3.bus_read_data; assign rdy[2] = b3.bus_ready; assign err[2] = b3.bus_err;
   assign tv[0] = b0.tohost_valid; assign td[0] = b0.tohost_data; assign st[0] = b0.state;
   assign tv[1] = b1.tohost_valid; assign td[1] = b1.tohost_data; assign st[1] = b1.state;
   assign tv[2] = b3.tohost_valid; assign td[2] = b3.tohost_data; assign st[2] = b3.state;

   // Reference model
   int          wc [3] = '{0, 1, 3};
   logic [31:0] mem_m [3][1024];
   logic [31:0] th_m [3];
   logic        tv_m [3];
   logic [31:0] exp_q [$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic do_txn(input logic r, input logic w, input logic [11:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input logic [2:0] m, input string tag);
      int          lat  [3];
      int          nrdy [3];
      logic [31:0] got_d [3];
      logic        got_e [3];
      logic [31:0] e;
      int          widx;
      bit          is_th;
      widx  = int'(a[11:2]);
      is_th = (a[11:2] == 10'h3FF);
      for (int i = 0; i < 3; i++) begin
         lat[i] = -1; nrdy[i] = 0; got_d[i] = '0; got_e[i] = 1'b0;
         if (m[i]) exp_q.push_back((r && !w) ? (is_th ? th_m[i] : mem_m[i][widx]) : 32'h0);
      end
      @(negedge clk);
      addr = a; rd = r; wr = w; be = b; wd = d; mask = m;
      @(negedge clk);
      // Scramble inputs: the responder must work from its latched copy.
      rd = 1'b0; wr = 1'b0; addr = 12'($urandom); be = 4'($urandom); wd = $urandom;
      for (int k = 1; k <= 6; k++) begin
         for (int i = 0; i < 3; i++) begin
            if (rdy[i] === 1'b1) begin
               nrdy[i]++;
               if (lat[i] < 0) lat[i] = k;
               got_d[i] = rdat[i];
               got_e[i] = err[i];
            end else begin
               n_cmp++;
               if (rdat[i] !== 32'h0 || err[i] !== 1'b0) begin
                  n_err++;
                  $display("FAIL %s idle_out dut%0d cyc%0d: data=%h err=%b want 0/0", tag, i, k, rdat[i], err[i]);
               end
            end
         end
         if (k < 6) @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         if (m[i]) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (nrdy[i] !== 1 || lat[i] !== wc[i] + 1) begin
               n_err++;
               $display("FAIL %s latency dut%0d: pulses=%0d lat=%0d want 1 pulse lat=%0d", tag, i, nrdy[i], lat[i], wc[i] + 1);
            end
            n_cmp++;
            if (got_d[i] !== e) begin
               n_err++;
               $display("FAIL %s rdata dut%0d: got %h want %h", tag, i, got_d[i], e);
            end
            n_cmp++;
            if (got_e[i] !== (r & w)) begin
               n_err++;
               $display("FAIL %s err dut%0d: got %b want %b", tag, i, got_e[i], r & w);
            end
            if (w && !r) begin
               if (is_th) begin
                  th_m[i] = d; tv_m[i] = 1'b1;
               end else begin
                  for (int l = 0; l < 4; l++) if (b[l]) mem_m[i][widx][l*8 +: 8] = d[l*8 +: 8];
               end
            end
         end else begin
            n_cmp++;
            if (nrdy[i] !== 0) begin
               n_err++;
               $display("FAIL %s unmasked dut%0d: pulses=%0d want 0", tag, i, nrdy[i]);
            end
         end
         n_cmp++;
         if (tv[i] !== tv_m[i] || td[i] !== th_m[i]) begin
            n_err++;
            $display("FAIL %s tohost dut%0d: valid=%b data=%h want %b/%h", tag, i, tv[i], td[i], tv_m[i], th_m[i]);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (rdy[i] !== 1'b0 || err[i] !== 1'b0 || rdat[i] !== 32'h0 ||
             tv[i] !== 1'b0 || td[i] !== 32'h0 || st[i] !== IDLE) begin
            n_err++;
            $display("FAIL %s dut%0d: rdy=%b err=%b data=%h tv=%b td=%h st=%0d want all zero/IDLE",
                     tag, i, rdy[i], err[i], rdat[i], tv[i], td[i], st[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wd = '0; mask = 3'b111;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin th_m[i] = '0; tv_m[i] = 1'b0; end
   endtask

   task automatic test_fill();
      for (int w = 0; w < 64; w++) do_txn(1'b0, 1'b1, 12'(w * 4), 4'hF, $urandom, 3'b111, "fill");
   endtask

   task automatic test_basic();
      do_txn(1'b0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF, 3'b111, "basic_wr");
      do_txn(1'b1, 1'b0, 12'h010, 4'hF, 32'h0, 3'b111, "basic_rd");
   endtask

   task automatic test_byte_lanes();
      do_txn(1'b0, 1'b1, 12'h020, 4'hF, 32'h11223344, 3'b111, "lane_init");
      do_txn(1'b0, 1'b1, 12'h020, 4'b0101, 32'hAABBCCDD, 3'b111, "lane_wr");
      do_txn(1'b1, 1'b0, 12'h020, 4'h0, 32'h0, 3'b111, "lane_rd");
      do_txn(1'b0, 1'b1, 12'h020, 4'h0, 32'h55555555, 3'b111, "lane_none");
      do_txn(1'b1, 1'b0, 12'h021, 4'h0, 32'h0, 3'b111, "lane_rd2");
   endtask

   task automatic test_error();
      do_txn(1'b0, 1'b1, 12'h030, 4'hF, 32'h5, 3'b111, "err_init");
      do_txn(1'b1, 1'b1, 12'h030, 4'hF, 32'h77777777, 3'b111, "err_req");
      do_txn(1'b1, 1'b0, 12'h030, 4'hF, 32'h0, 3'b111, "err_rd");
   endtask

   task automatic test_tohost();
      do_txn(1'b0, 1'b1, 12'hFFC, 4'hF, 32'h1, 3'b111, "th_wr");
      do_txn(1'b1, 1'b0, 12'hFFC, 4'hF, 32'h0, 3'b111, "th_rd");
      do_txn(1'b0, 1'b1, 12'hFFE, 4'h0, 32'h2, 3'b010, "th_wr_be0");
      do_txn(1'b1, 1'b0, 12'hFFC, 4'h0, 32'h0, 3'b111, "th_rd2");
   endtask

   task automatic test_back_to_back();
      int k_total;
      logic exp_r;
      k_total = 20;
      @(negedge clk);
      addr = 12'h010; rd = 1'b1; wr = 1'b0; be = 4'h0; mask = 3'b111;
      for (int k = 1; k <= k_total; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            // Held request: one completion every WAIT_CYCLES+2 cycles.
            exp_r = (k >= wc[i] + 1) && (((k - wc[i] - 1) % (wc[i] + 2)) == 0);
            n_cmp++;
            if (rdy[i] !== exp_r) begin
               n_err++;
               $display("FAIL b2b_ready dut%0d cyc%0d: got %b want %b", i, k, rdy[i], exp_r);
            end
            if (exp_r) begin
               n_cmp++;
               if (rdat[i] !== mem_m[i][4]) begin
                  n_err++;
                  $display("FAIL b2b_data dut%0d cyc%0d: got %h want %h", i, k, rdat[i], mem_m[i][4]);
               end
            end
         end
      end
      rd = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      addr = 12'h040; rd = 1'b0; wr = 1'b1; be = 4'hF; wd = 32'hCAFEF00D; mask = 3'b100;
      @(negedge clk);
      wr = 1'b0; rst = 1'b1;
      n_cmp++;
      if (st[2] !== WAIT) begin
         n_err++;
         $display("FAIL rstmid_state dut2: got %0d want %0d", st[2], WAIT);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin th_m[i] = '0; tv_m[i] = 1'b0; end
      for (int k = 0; k < 6; k++) begin
         check_reset_outputs("rstmid_out");
         @(negedge clk);
      end
      mask = 3'b111;
      do_txn(1'b1, 1'b0, 12'h040, 4'h0, 32'h0, 3'b111, "rstmid_rd");
   endtask

   task automatic test_random();
      int          kind;
      logic [11:0] a;
      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 9));
         a = ($urandom_range(0, 15) == 0) ? 12'hFFC : 12'($urandom_range(0, 63) * 4);
         do_txn(kind < 5 || kind == 9, kind >= 5, a, 4'($urandom), $urandom,
                3'($urandom_range(1, 7)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_basic();
      test_byte_lanes();
      test_error();
      test_tohost();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
